// File: rtl/grid_access_arbiter_if.sv
// Requester, response, RAM and clear-control signals of the grid cell RAM arbiter.
// Slave is the arbiter; master is whatever drives the requesters and models the RAM.
interface grid_access_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int COORD_W = 6,
    parameter int ADDR_W  = 10
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_we;
    logic [NUM_REQ*COORD_W-1:0] req_x;
    logic [NUM_REQ*COORD_W-1:0] req_y;
    logic [NUM_REQ*4-1:0]       req_wdata;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [3:0]                 rsp_rdata;
    logic                       mem_en;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [3:0]                 mem_wdata;
    logic [3:0]                 mem_rdata;
    logic                       clear_start;
    logic                       clear_busy;
    logic                       clear_done;

    modport master (
        output req_valid, req_we, req_x, req_y, req_wdata, mem_rdata, clear_start,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               clear_busy, clear_done
    );

    modport slave (
        input  req_valid, req_we, req_x, req_y, req_wdata, mem_rdata, clear_start,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               clear_busy, clear_done
    );
endinterface

// File: rtl/grid_access_arbiter.sv
// Round-robin arbiter sharing the single-port grid cell RAM between requesters,
// with an in-order two-stage response pipeline and a whole-grid clear engine.

// Per-requester coordinate decode: bounds check and linear cell address.
module grid_req_decode #(
    parameter int GRID_X  = 32,
    parameter int GRID_Y  = 24,
    parameter int COORD_W = 6,
    parameter int ADDR_W  = 10
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic               o_oob,
    output logic [ADDR_W-1:0]  o_addr
);
    assign o_oob  = (32'(i_x) >= 32'(GRID_X)) || (32'(i_y) >= 32'(GRID_Y));
    assign o_addr = o_oob ? '0 : ADDR_W'(32'(i_y) * 32'(GRID_X) + 32'(i_x));
endmodule

module grid_access_arbiter #(
    parameter int         NUM_REQ    = 3,
    parameter int         GRID_X     = 32,
    parameter int         GRID_Y     = 24,
    parameter int         COORD_W    = 6,
    parameter int         ADDR_W     = 10,
    parameter logic [3:0] OOB_CODE   = 4'b0010,
    parameter logic [3:0] CLEAR_CODE = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst,
    grid_access_arbiter_if.slave  bus
);
    localparam int              CELLS    = GRID_X * GRID_Y;
    localparam int              RR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(CELLS);

    typedef enum logic {S_CLEAR, S_ARB} state_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] owner;
        logic               we;
        logic               oob;
    } pipe_t;

    state_t                          r_state;
    logic [ADDR_W:0]                 r_cnt;
    logic [RR_W-1:0]                 r_rr;
    logic                            r_mem_en;
    logic                            r_mem_we;
    logic [ADDR_W-1:0]               r_mem_addr;
    logic [3:0]                      r_mem_wdata;
    logic                            r_clear_done;
    logic [2:1]                      r_vld_pipe;
    pipe_t                           r_p1;
    pipe_t                           r_p2;

    logic [NUM_REQ-1:0][COORD_W-1:0] w_x;
    logic [NUM_REQ-1:0][COORD_W-1:0] w_y;
    logic [NUM_REQ-1:0][3:0]         w_wdata;
    logic [NUM_REQ-1:0]              w_oob;
    logic [NUM_REQ-1:0][ADDR_W-1:0]  w_addr;
    logic                            w_gnt_found;
    logic [RR_W-1:0]                 w_gnt_idx;
    logic [NUM_REQ-1:0]              w_req_ready;
    logic                            w_accept;
    logic                            w_sel_we;
    logic                            w_sel_oob;
    logic [ADDR_W-1:0]               w_sel_addr;
    logic [3:0]                      w_sel_wdata;

    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return RR_W'(s);
    endfunction

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
            assign w_x[g]     = bus.req_x[g*COORD_W +: COORD_W];
            assign w_y[g]     = bus.req_y[g*COORD_W +: COORD_W];
            assign w_wdata[g] = bus.req_wdata[g*4 +: 4];

            grid_req_decode #(
                .GRID_X (GRID_X),
                .GRID_Y (GRID_Y),
                .COORD_W(COORD_W),
                .ADDR_W (ADDR_W)
            ) u_dec (
                .i_x   (w_x[g]),
                .i_y   (w_y[g]),
                .o_oob (w_oob[g]),
                .o_addr(w_addr[g])
            );
        end
    endgenerate

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_gnt_found && bus.req_valid[rr_next(r_rr, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = rr_next(r_rr, k);
            end
        end
    end

    assign w_accept    = w_gnt_found && (r_state == S_ARB);
    assign w_req_ready = w_accept ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_sel_we    = bus.req_we[w_gnt_idx];
    assign w_sel_oob   = w_oob[w_gnt_idx];
    assign w_sel_addr  = w_addr[w_gnt_idx];
    assign w_sel_wdata = w_wdata[w_gnt_idx];

    // The mem_* registers have one owner per cycle: a RAM op accepted in the
    // clear_start cycle goes out first, so the sweep naturally starts a cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_rr         <= RR_W'(NUM_REQ - 1);
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            case (r_state)
                S_CLEAR: begin
                    if (bus.clear_start) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state      <= S_ARB;
                        r_cnt        <= '0;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_cnt[ADDR_W-1:0];
                        r_mem_wdata <= CLEAR_CODE;
                        r_cnt       <= r_cnt + (ADDR_W+1)'(1);
                    end
                end
                S_ARB: begin
                    if (w_accept) begin
                        r_rr <= w_gnt_idx;
                        if (!w_sel_oob) begin
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= w_sel_we;
                            r_mem_addr  <= w_sel_addr;
                            r_mem_wdata <= w_sel_we ? w_sel_wdata : 4'b0000;
                        end
                    end
                    if (bus.clear_start) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Response pipeline runs in every state so accepted requests always complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
        end else begin
            r_vld_pipe[1] <= w_accept;
            r_vld_pipe[2] <= r_vld_pipe[1];
            r_p1          <= {w_req_ready, w_sel_we, w_sel_oob};
            r_p2          <= r_p1;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.clear_busy = (r_state == S_CLEAR);
    assign bus.clear_done = r_clear_done;
    assign bus.rsp_valid  = r_vld_pipe[2] ? r_p2.owner : '0;
    // RAM read data lands in the response cycle itself, so the mux stays combinational.
    assign bus.rsp_rdata  = (r_vld_pipe[2] && !r_p2.we) ? (r_p2.oob ? OOB_CODE : bus.mem_rdata)
                                                        : 4'b0000;
endmodule

// File: tb/tb_grid_access_arbiter.sv
// Randomized bench for grid_access_arbiter against a cycle-level reference of the
// grid contents, round-robin order, clear sweep timing and response latency.
module tb_grid_access_arbiter;
    localparam int NR    = 3;
    localparam int CW    = 6;
    localparam int AW    = 10;
    localparam int GX    = 32;
    localparam int GY    = 24;
    localparam int CELLS = GX * GY;
    localparam int BIG   = 1 << 29;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grid_access_arbiter_if #(.NUM_REQ(NR), .COORD_W(CW), .ADDR_W(AW)) bus ();

    grid_access_arbiter #(
        .NUM_REQ(NR), .GRID_X(GX), .GRID_Y(GY), .COORD_W(CW), .ADDR_W(AW),
        .OOB_CODE(4'b0010), .CLEAR_CODE(4'b0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural RAM, seeded with junk so a skipped clear would show up in reads.
    logic [3:0] ram [0:(1<<AW)-1];
    bit         ram_seeded = 1'b0;
    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= 4'($urandom_range(15, 1));
            ram_seeded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        int         due;
        int         owner;
        logic [3:0] data;
    } rsp_t;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         clr_from, clr_base, last_gnt;
    int         mo_cyc;
    logic       mo_we;
    logic [AW-1:0] mo_addr;
    logic [3:0] mo_wd;
    logic [3:0] gold [0:CELLS-1];
    rsp_t       rq [$];

    logic [NR-1:0] p_v = '0;
    logic [NR-1:0] p_we = '0;
    logic [CW-1:0] p_x [NR];
    logic [CW-1:0] p_y [NR];
    logic [3:0]    p_wd [NR];
    bit            rnd_en = 1'b0;
    int            rnd_pct = 0;
    bit            clr_req = 1'b0;
    bit            rst_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic mdl_reset();
        clr_from = 0;
        clr_base = BIG;
        last_gnt = NR - 1;
        mo_cyc   = -1;
        rq.delete();
        for (int i = 0; i < CELLS; i++) gold[i] = 4'b0000;
    endtask

    function automatic logic [CW-1:0] pick(input int lim);
        int r;
        r = $urandom_range(9);
        if (r < 7)       return CW'($urandom_range(3));
        else if (r == 7) return CW'(lim - 1);
        else             return CW'($urandom_range(63, lim));
    endfunction

    task automatic set_req(input int i, input bit we, input int x, input int y, input int wd);
        p_v[i]  = 1'b1;
        p_we[i] = we;
        p_x[i]  = CW'(x);
        p_y[i]  = CW'(y);
        p_wd[i] = 4'(wd);
    endtask

    task automatic check_outputs();
        bit busy_exp;
        busy_exp = (cyc >= clr_from) && (cyc < clr_base + CELLS);
        chk("clear_busy", 32'(bus.clear_busy), 32'(busy_exp));
        chk("clear_done", 32'(bus.clear_done), 32'(cyc == clr_base + CELLS));
        if (cyc >= clr_base && cyc < clr_base + CELLS) begin
            chk("clr_en",    32'(bus.mem_en),    32'd1);
            chk("clr_we",    32'(bus.mem_we),    32'd1);
            chk("clr_addr",  32'(bus.mem_addr),  32'(cyc - clr_base));
            chk("clr_wdata", 32'(bus.mem_wdata), 32'd0);
        end else if (mo_cyc == cyc) begin
            chk("op_en",   32'(bus.mem_en),   32'd1);
            chk("op_we",   32'(bus.mem_we),   32'(mo_we));
            chk("op_addr", 32'(bus.mem_addr), 32'(mo_addr));
            if (mo_we) chk("op_wdata", 32'(bus.mem_wdata), 32'(mo_wd));
        end else begin
            chk("idle_en", 32'(bus.mem_en), 32'd0);
            chk("idle_we", 32'(bus.mem_we), 32'd0);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1 << rq[0].owner);
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rq[0].data));
            void'(rq.pop_front());
        end else begin
            chk("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    task automatic model_step();
        bit            in_clear;
        logic [NR-1:0] exp_rdy;
        int            g, addr;
        bit            oob;
        logic [3:0]    d;
        in_clear = (cyc >= clr_from) && (cyc < clr_base + CELLS);
        exp_rdy  = '0;
        g        = -1;
        if (!in_clear) begin
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && p_v[(last_gnt + k) % NR]) g = (last_gnt + k) % NR;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            last_gnt = g;
            oob  = (int'(p_x[g]) >= GX) || (int'(p_y[g]) >= GY);
            addr = int'(p_y[g]) * GX + int'(p_x[g]);
            if (!oob) begin
                mo_cyc  = cyc + 1;
                mo_we   = p_we[g];
                mo_addr = AW'(addr);
                mo_wd   = p_wd[g];
            end
            if (p_we[g])  d = 4'b0000;
            else if (oob) d = 4'b0010;
            else          d = gold[addr];
            if (p_we[g] && !oob) gold[addr] = p_wd[g];
            rq.push_back('{due: cyc + 2, owner: g, data: d});
            p_v[g] = 1'b0;
        end
        if (clr_req) begin
            if (!in_clear) clr_from = cyc + 1;
            clr_base = cyc + 2;
            for (int i = 0; i < CELLS; i++) gold[i] = 4'b0000;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (rst_req) begin
            rst     = 1'b1;
            rst_req = 1'b0;
            mdl_reset();
        end else if (rst) begin
            rst      = 1'b0;
            clr_base = cyc + 1;
        end
        if (rnd_en) begin
            for (int i = 0; i < NR; i++) begin
                if (!p_v[i] && $urandom_range(99) < rnd_pct)
                    set_req(i, 1'($urandom_range(1)), int'(pick(GX)), int'(pick(GY)),
                            int'($urandom_range(15)));
            end
        end
        bus.req_valid   = p_v;
        bus.req_we      = p_we;
        bus.clear_start = clr_req;
        for (int i = 0; i < NR; i++) begin
            bus.req_x[i*CW +: CW]   = p_x[i];
            bus.req_y[i*CW +: CW]   = p_y[i];
            bus.req_wdata[i*4 +: 4] = p_wd[i];
        end
        #1;
        if (!rst) model_step();
        clr_req = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int max);
        int c;
        c = 0;
        while (p_v != '0 && c < max) begin
            cycle();
            c++;
        end
        chk("drain_timeout", 32'(p_v), 32'd0);
        run(3);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            p_x[i]  = '0;
            p_y[i]  = '0;
            p_wd[i] = '0;
        end
        bus.req_valid   = '0;
        bus.req_we      = '0;
        bus.req_x       = '0;
        bus.req_y       = '0;
        bus.req_wdata   = '0;
        bus.clear_start = 1'b0;
        mdl_reset();

        // Power-up sweep with nobody requesting.
        run(CELLS + 8);

        // Write then read the same cell from different requesters.
        set_req(1, 1'b1, 15, 15, 1);
        cycle();
        set_req(0, 1'b0, 15, 15, 0);
        cycle();
        run(4);

        // Three requesters reading back-to-back: strict rotation, no bubbles.
        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < NR; i++) if (!p_v[i]) set_req(i, 1'b0, i, 0, 0);
            cycle();
        end
        p_v = '0;
        run(4);

        // Out-of-grid accesses.
        set_req(0, 1'b0, 63, 15, 0);
        set_req(1, 1'b0, 5, 24, 0);
        set_req(2, 1'b1, 32, 0, 9);
        drain(10);

        // Mixed random traffic.
        rnd_en  = 1'b1;
        rnd_pct = 60;
        run(1500);
        rnd_en = 1'b0;
        drain(20);

        // clear_start together with an accepted write, then a restart mid-sweep.
        set_req(2, 1'b1, 1, 1, 7);
        clr_req = 1'b1;
        cycle();
        run(400);
        clr_req = 1'b1;
        cycle();
        run(CELLS + 8);
        set_req(0, 1'b0, 1, 1, 0);
        drain(10);

        // Reset while a read is in flight.
        set_req(0, 1'b0, 2, 2, 0);
        cycle();
        rst_req = 1'b1;
        cycle();
        run(CELLS + 8);

        rnd_en  = 1'b1;
        rnd_pct = 40;
        run(300);
        rnd_en = 1'b0;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/grid_access_arbiter.md
Name: grid_access_arbiter

Overview:
- Shares the single-port grid cell RAM (GRID_X×GRID_Y cells, 4-bit cell codes: NULL/SNAKE/ROCK/SNACK) between NUM_REQ requesters: game controller, snack generator, display reader.
- Uses round-robin arbitration with a valid/ready request handshake and an in-order response pipeline.
- Contains a clear engine that sweeps the whole grid to CLEAR_CODE after reset or on command.
- Out-of-grid coordinates are resolved without a RAM access: reads see a wall, writes are dropped.

Parameters:
- NUM_REQ, 3, number of requester ports; index 0 has the highest initial priority.
- GRID_X, 32, grid width in cells.
- GRID_Y, 24, grid height in cells.
- COORD_W, 6, coordinate width per axis; values ≥ GRID_X or ≥ GRID_Y are out-of-bounds (OOB).
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W ≥ GRID_X*GRID_Y.
- OOB_CODE, 4'b0010, read data returned for OOB reads (ROCK).
- CLEAR_CODE, 4'b0000, value written by the clear engine (NULL).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (at most one bit high).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_x  in  NUM_REQ*COORD_W  x coordinates, flattened, requester i at [i*COORD_W +: COORD_W].
- req_y  in  NUM_REQ*COORD_W  y coordinates, flattened likewise.
- req_wdata  in  NUM_REQ*4  write cell codes, flattened.
- rsp_valid  out  NUM_REQ  response strobe to the owning requester.
- rsp_rdata  out  4  response data, shared by all requesters; qualified by rsp_valid.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address = y*GRID_X + x.
- mem_wdata  out  4  RAM write data.
- mem_rdata  in  4  RAM read data; synchronous, valid the cycle after mem_en.
- clear_start  in  1  single-cycle pulse that starts a grid clear.
- clear_busy  out  1  high while the clear engine is sweeping.
- clear_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Reset values: state = CLEAR, clear counter = 0, RR pointer = NUM_REQ-1 (so requester 0 wins first). mem_en, mem_we, mem_addr, mem_wdata = 0. rsp_valid = 0, rsp_rdata = 0, clear_done = 0, pipeline valid bits = 0.
- States:
  - CLEAR: each cycle drive mem_en=1, mem_we=1, mem_addr=counter, mem_wdata=CLEAR_CODE; counter increments. After address GRID_X*GRID_Y-1 is written: counter = 0, clear_done pulses 1 cycle, state → ARB. clear_busy = 1 throughout CLEAR. req_ready = 0 throughout CLEAR.
  - ARB: req_ready is combinational. Grant goes to the first requester with req_valid=1, searching from RR pointer+1 upward with wrap. Only the granted bit of req_ready is 1; with no valid requests req_ready = 0.
- Handshake: accept = valid & ready in cycle T. A requester must hold valid, we, x, y and wdata stable until accepted. On accept, the RR pointer is set to the granted index; with no grant the pointer holds.
- Pipeline (accepted in cycle T):
  - In-bounds: mem_en=1 with the request's we, addr and wdata, registered and driven in T+1.
  - OOB: no RAM access in T+1 (mem_en=0), and writes are discarded.
  - In all cases rsp_valid[i] = 1 for exactly one cycle at T+2.
  - rsp_rdata at T+2: in-bounds read = mem_rdata; OOB read = OOB_CODE; any write = 0 (ack only).
  - Throughput is one request per cycle; responses return strictly in acceptance order.
- Address arithmetic: y*GRID_X + x computed at full width, then truncated to ADDR_W; computed only for in-bounds coordinates.
- Consecutive write then read of the same cell on successive cycles: the read returns the new value, because the RAM ops fall in different cycles.
- clear_start in ARB: state → CLEAR next cycle, counter = 0.
  - Any request accepted in that same cycle completes normally: its RAM op occupies T+1, so the clear's first write is delayed to T+2.
  - Rule: the clear engine never drives mem_* while a pipeline stage holds a valid RAM op.
- clear_start during CLEAR: counter restarts at 0; clear_done is not pulsed for the aborted sweep.
- rst asserted mid-operation: in-flight responses are dropped (rsp_valid = 0); a fresh clear begins after release.

Test Plan:
1. Release rst with all req_valid = 0 → mem_we=1 for 768 consecutive cycles, addresses 0..767, data 0; clear_done pulses once; clear_busy falls the same cycle; req_ready stays 0 until ARB.
2. After clear, requester 1 writes (x=15, y=15, 4'b0001), then requester 0 reads (15,15) → mem_addr = 495 for both ops; rsp_valid[1] at T+2 with data 0; rsp_valid[0] returns 4'b0001.
3. All three requesters hold valid reads continuously → grants cycle 0,1,2,0,1,2; each requester gets exactly one rsp_valid per grant, in order, with no bubbles.
4. Read at x=63, y=15, and read at x=5, y=24 → mem_en stays 0; rsp_rdata = 4'b0010. Write at x=32 → no RAM write; ack returned with rsp_rdata = 0.
5. clear_start in the same cycle as an accepted write → the write reaches the RAM first, then a full 768-write sweep follows; clear_done fires once. A second clear_start mid-sweep restarts the sweep at address 0.
6. Assert rst while a read is in the pipeline → rsp_valid stays 0 and no response is lost-then-delivered late; the sweep restarts from address 0.
